// File: rtl/mbconv_pkg.sv
// Shared types and helpers for the MBConv layer-1 to layer-2 writeback path.
// Holds the sequencer state encoding, default lane geometry and the lane slice helper.
package mbconv_pkg;

    localparam int NUM_PE_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } wb_state_t;

    // Bit offset of a lane inside a packed pixel word.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/ofm_skid_fifo.sv
// Small skid FIFO that buffers packed pixel words ahead of the writeback sequencer.
// Pointers carry one extra wrap bit so that full and empty need no separate counter.
module ofm_skid_fifo #(
    parameter int DATA  = 128,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [DATA-1:0] push_data,
    input  logic            pop,
    output logic [DATA-1:0] pop_data,
    output logic            full,
    output logic            empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA-1:0] mem [DEPTH];
    logic [AW:0]     wr_ptr_reg;
    logic [AW:0]     rd_ptr_reg;
    logic            push_ok;
    logic            pop_ok;

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // A push at full is dropped even when a pop happens in the same cycle.
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mbconv_ofm_writeback.sv
// Self-sequenced OFM writer: packs lane results, applies optional ReLU, inserts the
// zero padding border and walks raster addresses per channel tile into the IFM buffer.
module mbconv_ofm_writeback
    import mbconv_pkg::*;
#(
    parameter int NUM_PE     = NUM_PE_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [7:0]               ofm_w,
    input  logic [7:0]               num_tiles,
    input  logic                     pad_en,
    input  logic                     relu_en,
    input  logic                     in_valid,
    input  logic [NUM_PE*DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [NUM_PE*DATA_W-1:0] wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow_err
);
    localparam int WORD_W = NUM_PE * DATA_W;

    wb_state_t          state_reg;
    wb_state_t          state_next;

    logic [ADDR_W-1:0]  base_reg;
    logic [8:0]         pw_reg;
    logic [7:0]         tiles_reg;
    logic               pad_reg;
    logic               relu_reg;

    logic [7:0]         tile_reg;
    logic [8:0]         row_reg;
    logic [8:0]         col_reg;
    logic [ADDR_W-1:0]  offset_reg;

    logic               wr_en_reg;
    logic [ADDR_W-1:0]  wr_addr_reg;
    logic [WORD_W-1:0]  wr_data_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               overflow_reg;

    logic               fifo_full;
    logic               fifo_empty;
    logic [WORD_W-1:0]  fifo_data;
    logic [WORD_W-1:0]  relu_data;

    logic               accept_start;
    logic               cfg_ok;
    logic               col_last;
    logic               row_last;
    logic               tile_last;
    logic               border;
    logic               fire;
    logic               pop;

    ofm_skid_fifo #(
        .DATA  (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid && in_ready),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Ready is forced low while reset is held so every output reads 0 during reset.
    assign in_ready     = !fifo_full && !reset;
    assign wr_en        = wr_en_reg;
    assign wr_addr      = wr_addr_reg;
    assign wr_data      = wr_data_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign overflow_err = overflow_reg;

    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_lane
        logic [DATA_W-1:0] lane;
        assign lane = fifo_data[lane_lsb(gi, DATA_W) +: DATA_W];
        assign relu_data[lane_lsb(gi, DATA_W) +: DATA_W] =
            (relu_reg && lane[DATA_W-1]) ? '0 : lane;
    end

    assign accept_start = start && (state_reg == IDLE);
    assign cfg_ok       = (ofm_w != 8'd0) && (num_tiles != 8'd0);
    assign col_last     = (col_reg == pw_reg - 9'd1);
    assign row_last     = (row_reg == pw_reg - 9'd1);
    assign tile_last    = (tile_reg == tiles_reg - 8'd1);
    assign border       = pad_reg && ((row_reg == 9'd0) || row_last ||
                                      (col_reg == 9'd0) || col_last);
    // Border positions never consume input; interior positions wait for a word.
    assign fire         = (state_reg == RUN) && (border || !fifo_empty);
    assign pop          = (state_reg == RUN) && !border && !fifo_empty;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept_start) begin
                    state_next = cfg_ok ? RUN : FIN;
                end
            end
            RUN: begin
                if (fire && col_last && row_last && tile_last) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            pw_reg       <= '0;
            tiles_reg    <= '0;
            pad_reg      <= 1'b0;
            relu_reg     <= 1'b0;
            tile_reg     <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            offset_reg   <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            wr_en_reg <= fire;
            done_reg  <= (state_reg == FIN);

            if (in_valid && fifo_full) begin
                overflow_reg <= 1'b1;
            end else if (accept_start) begin
                overflow_reg <= 1'b0;
            end

            if (accept_start) begin
                base_reg   <= base_addr;
                pw_reg     <= {1'b0, ofm_w} + {7'b0, pad_en, 1'b0};
                tiles_reg  <= num_tiles;
                pad_reg    <= pad_en;
                relu_reg   <= relu_en;
                tile_reg   <= '0;
                row_reg    <= '0;
                col_reg    <= '0;
                offset_reg <= '0;
                busy_reg   <= cfg_ok;
            end else if (state_reg == FIN) begin
                busy_reg   <= 1'b0;
            end

            // Raster order is contiguous, so the address offset is a plain counter.
            if (fire) begin
                offset_reg  <= offset_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
                wr_addr_reg <= base_reg + offset_reg;
                wr_data_reg <= border ? '0 : relu_data;
                if (col_last) begin
                    col_reg <= '0;
                    if (row_last) begin
                        row_reg  <= '0;
                        tile_reg <= tile_reg + 8'd1;
                    end else begin
                        row_reg <= row_reg + 9'd1;
                    end
                end else begin
                    col_reg <= col_reg + 9'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mbconv_ofm_writeback.sv
// Scoreboard bench for mbconv_ofm_writeback: tests queue expected writes, a negedge
// monitor pops and compares every wr_en beat and checks done placement.
module tb_mbconv_ofm_writeback;
    localparam int NUM_PE = 16;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 32;
    localparam int W      = NUM_PE * DATA_W;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [W-1:0]      data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [7:0]        ofm_w = '0;
    logic [7:0]        num_tiles = '0;
    logic              pad_en = 1'b0;
    logic              relu_en = 1'b0;
    logic              in_valid = 1'b0;
    logic [W-1:0]      in_data = '0;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [W-1:0]      wr_data;
    logic              busy;
    logic              done;
    logic              overflow_err;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   wr_count = 0;
    int   run_len = 0;
    int   max_run = 0;
    logic prev_wr_en = 1'b0;
    logic exp_wr_before_done = 1'b1;

    mbconv_ofm_writeback #(
        .NUM_PE(NUM_PE), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .ofm_w(ofm_w), .num_tiles(num_tiles), .pad_en(pad_en), .relu_en(relu_en),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (wr_en) begin
                wr_count++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write addr=%h data=%h", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (wr_addr !== e.addr || wr_data !== e.data) begin
                        bad++;
                        $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                                 wr_addr, wr_data, e.addr, e.data);
                    end else begin
                        $display("write addr=%h data=%h ok", wr_addr, wr_data);
                    end
                end
            end else begin
                run_len = 0;
            end
            if (done) begin
                total++;
                if (prev_wr_en !== exp_wr_before_done) begin
                    bad++;
                    $display("FAIL done_timing got prev_wr_en=%b want %b", prev_wr_en, exp_wr_before_done);
                end else begin
                    $display("done pulse ok");
                end
            end
            prev_wr_en = wr_en;
        end else begin
            prev_wr_en = 1'b0;
            run_len = 0;
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, expv);
        end else begin
            $display("check %s ok", name);
        end
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [W-1:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [7:0] w, input logic [7:0] t,
                            input logic p, input logic r);
        base_addr = b; ofm_w = w; num_tiles = t; pad_en = p; relu_en = r;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] d);
        int guard = 0;
        in_data = d;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) begin
            total++; bad++;
            $display("FAIL send_timeout in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s done_timeout got done=0 want 1", name);
        end
        @(negedge clk); #1;
        chk({name, "_queue_left"}, W'(exp_q.size()), W'(0));
    endtask

    function automatic logic [W-1:0] mk_word(input int k);
        logic [W-1:0] v;
        for (int i = 0; i < NUM_PE; i++) v[i*DATA_W +: DATA_W] = 8'(k * 16 + i + 1);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] words[8];
        logic [W-1:0] rw;
        logic [W-1:0] rexp;
        int idx;
        int cnt0;

        // Reset state while reset is held.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", W'(wr_en), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_ovf", W'(overflow_err), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(0));
        chk("rst_wr_addr", W'(wr_addr), W'(0));
        chk("rst_wr_data", wr_data, W'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", W'(in_ready), W'(1));

        // 2x2, no pad, four words streamed back to back.
        for (int k = 0; k < 4; k++) begin
            words[k] = mk_word(k);
            push_exp(32'h100 + 32'(k), words[k]);
        end
        max_run = 0;
        do_start(32'h100, 8'd2, 8'd1, 1'b0, 1'b0);
        chk("t1_busy", W'(busy), W'(1));
        for (int k = 0; k < 4; k++) send_word(words[k]);
        wait_done("t1");
        chk("t1_back_to_back", W'(max_run), W'(4));
        chk("t1_busy_end", W'(busy), W'(0));

        // Address wrap at the top of the address space.
        for (int k = 0; k < 4; k++) words[k] = mk_word(k + 4);
        push_exp(32'hFFFF_FFFE, words[0]);
        push_exp(32'hFFFF_FFFF, words[1]);
        push_exp(32'h0000_0000, words[2]);
        push_exp(32'h0000_0001, words[3]);
        do_start(32'hFFFF_FFFE, 8'd2, 8'd1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) send_word(words[k]);
        wait_done("t_wrap");

        // Padded 2x2, two tiles: PW=4, 32 writes, zero border.
        for (int k = 0; k < 8; k++) words[k] = mk_word(k + 8);
        idx = 0;
        for (int t = 0; t < 2; t++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (r == 0 || r == 3 || c == 0 || c == 3) begin
                        push_exp(32'(t * 16 + r * 4 + c), W'(0));
                    end else begin
                        push_exp(32'(t * 16 + r * 4 + c), words[idx]);
                        idx++;
                    end
                end
        do_start(32'h0, 8'd2, 8'd2, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) send_word(words[k]);
        wait_done("t2");

        // ReLU on and off with lanes 0x80, 0x7F, 0xFF.
        for (int i = 0; i < NUM_PE; i++) rw[i*DATA_W +: DATA_W] = 8'(8'h10 + i);
        rw[7:0] = 8'h80;
        rw[15:8] = 8'h7F;
        rw[23:16] = 8'hFF;
        rexp = rw;
        rexp[7:0] = 8'h00;
        rexp[23:16] = 8'h00;
        push_exp(32'h200, rexp);
        do_start(32'h200, 8'd1, 8'd1, 1'b0, 1'b1);
        send_word(rw);
        wait_done("t3_relu_on");
        push_exp(32'h300, rw);
        do_start(32'h300, 8'd1, 8'd1, 1'b0, 1'b0);
        send_word(rw);
        wait_done("t3_relu_off");

        // Overflow: fill FIFO in IDLE, then present a fifth word.
        for (int k = 0; k < 4; k++) begin
            words[k] = mk_word(k + 20);
            push_exp(32'h500 + 32'(k), words[k]);
            send_word(words[k]);
        end
        chk("t4_full_ready", W'(in_ready), W'(0));
        in_data = mk_word(30);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t4_ovf_set", W'(overflow_err), W'(1));
        @(posedge clk); #1;
        chk("t4_ovf_sticky", W'(overflow_err), W'(1));
        do_start(32'h500, 8'd2, 8'd1, 1'b0, 1'b0);
        chk("t4_ovf_clear", W'(overflow_err), W'(0));
        wait_done("t4");
        chk("t4_ready_after", W'(in_ready), W'(1));

        // Zero-sized configurations: no writes, done two cycles after start.
        exp_wr_before_done = 1'b0;
        do_start(32'h700, 8'd2, 8'd0, 1'b0, 1'b0);
        chk("t5a_done_early", W'(done), W'(0));
        chk("t5a_busy", W'(busy), W'(0));
        @(posedge clk); #1;
        chk("t5a_done", W'(done), W'(1));
        chk("t5a_busy2", W'(busy), W'(0));
        @(posedge clk); #1;
        chk("t5a_done_off", W'(done), W'(0));
        do_start(32'h700, 8'd0, 8'd1, 1'b1, 1'b0);
        chk("t5b_done_early", W'(done), W'(0));
        @(posedge clk); #1;
        chk("t5b_done", W'(done), W'(1));
        chk("t5b_busy", W'(busy), W'(0));
        @(posedge clk); #1;
        exp_wr_before_done = 1'b1;

        // Reset during row 1 of a padded 3x3 tile with words still buffered.
        idx = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                if (r == 0 || r == 4 || c == 0 || c == 4) begin
                    push_exp(32'h600 + 32'(r * 5 + c), W'(0));
                end else begin
                    push_exp(32'h600 + 32'(r * 5 + c), mk_word(40 + idx));
                    idx++;
                end
            end
        cnt0 = wr_count;
        do_start(32'h600, 8'd3, 8'd1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) send_word(mk_word(40 + k));
        for (int n = 0; n < 100 && wr_count < cnt0 + 6; n++) begin
            @(negedge clk); #1;
        end
        chk("t6_reached_row1", W'(wr_count >= cnt0 + 6), W'(1));
        reset = 1'b1;
        #1;
        chk("t6_wr_en", W'(wr_en), W'(0));
        chk("t6_wr_addr", W'(wr_addr), W'(0));
        chk("t6_wr_data", wr_data, W'(0));
        chk("t6_busy", W'(busy), W'(0));
        chk("t6_done", W'(done), W'(0));
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("t6_ready", W'(in_ready), W'(1));
        push_exp(32'h40, mk_word(60));
        do_start(32'h40, 8'd1, 8'd1, 1'b0, 1'b0);
        send_word(mk_word(60));
        wait_done("t6_fresh");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
